// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: FSM state encoding and full-scale level helper.
package led_fade_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } fade_state_t;

    function automatic int unsigned level_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator: free-running 0..MAX-1 counter, duty latched at period start, registered compare.
module led_pwm_gen
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d  = (cnt_q == MAX - ONE) ? '0 : cnt_q + ONE;
        // The compare at period start already uses the newly latched duty.
        duty_d = (cnt_q == '0) ? duty_i : duty_q;
        pwm_d  = (cnt_q < duty_d);
        if (!en_i) begin
            duty_d = '0;
            pwm_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_fade_driver.sv
// Breathing LED driver: synchronized blink input ramps a PWM brightness level up/down.
// Optional macro LED_FADE_GAMMA_EN applies a squared (gamma) duty curve.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 195
) (
    input  logic                CLOCK_50,
    input  logic                RST_N,
    input  logic                blink_in,
    input  logic                enable,
    output logic                led_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                fade_done
);

    localparam int unsigned         PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]       TICK_AT = PW'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX     = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);

    logic                sync1_q, bs_q;
    fade_state_t         state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                done_q, done_d;
    logic                tick;
    logic [PWM_BITS-1:0] duty;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            bs_q    <= 1'b0;
            state_q <= S_OFF;
            presc_q <= '0;
            level_q <= '0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= blink_in;
            bs_q    <= sync1_q;
            state_q <= state_d;
            presc_q <= presc_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RISE) || (state_q == S_FALL);
    assign tick = busy && (presc_q == TICK_AT);

    // A ramp already at its end level (after a reversal) completes on its next tick.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF:   if (bs_q) state_d = S_RISE;
                S_RISE:  if (!bs_q) state_d = S_FALL;
                         else if (tick && level_q >= MAX - ONE) state_d = S_ON;
                S_ON:    if (!bs_q) state_d = S_FALL;
                S_FALL:  if (bs_q) state_d = S_RISE;
                         else if (tick && level_q <= ONE) state_d = S_OFF;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        if ((state_d != S_RISE && state_d != S_FALL) || state_d != state_q || tick) begin
            presc_d = '0;
        end

        level_d = level_q;
        if (!enable) begin
            level_d = '0;
        end else if (tick && state_q == S_RISE && state_d != S_FALL && level_q != MAX) begin
            level_d = level_q + ONE;
        end else if (tick && state_q == S_FALL && state_d != S_RISE && level_q != '0) begin
            level_d = level_q - ONE;
        end

        done_d = enable && ((state_q == S_RISE && state_d == S_ON) ||
                            (state_q == S_FALL && state_d == S_OFF));
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    assign duty     = (level_q == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    led_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk_i (CLOCK_50),
        .rst_ni(RST_N),
        .en_i  (enable),
        .duty_i(duty),
        .pwm_o (led_out)
    );

    assign level     = level_q;
    assign fade_done = done_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver with PWM_BITS=4, STEP_DIV=4.
module tb_led_fade_driver;

    localparam int unsigned PB = 4;
    localparam int unsigned SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          blink = 1'b0;
    logic          en = 1'b1;
    logic          led;
    logic [PB-1:0] lvl;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    led_fade_driver #(
        .PWM_BITS(PB),
        .STEP_DIV(SD)
    ) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .blink_in (blink),
        .enable   (en),
        .led_out  (led),
        .level    (lvl),
        .busy     (busy),
        .fade_done(done)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_level(input logic [PB-1:0] target, input int limit, output int n);
        n = 0;
        while (lvl !== target && n < limit) begin
            @(negedge clk);
            n++;
            if (done) done_cnt++;
        end
    endtask

    task automatic count_high(input int k, output int high);
        high = 0;
        repeat (k) begin
            @(negedge clk);
            if (led) high++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, high, mx, l6, l7, dc, idle_bad;

        push_exp("rst_led", 0);
        push_exp("rst_level", 0);
        push_exp("rst_busy", 0);
        push_exp("rst_done", 0);
        @(negedge clk);
        pop_check(led);
        pop_check(lvl);
        pop_check(busy);
        pop_check(done);
        @(negedge clk);
        rst_n = 1'b1;

        push_exp("idle_activity", 0);
        idle_bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lvl !== '0) idle_bad++;
        end
        pop_check(idle_bad);

        // Rise from OFF to ON
        blink = 1'b1;
        push_exp("rise_busy_2edges", 0);
        push_exp("rise_busy_3edges", 1);
        push_exp("rise_cycles", 60);
        push_exp("on_busy", 0);
        push_exp("on_done_flag", 1);
        push_exp("rise_done_pulses", 1);
        push_exp("on_led_high", 30);
        @(negedge clk);
        @(negedge clk);
        pop_check(busy);
        @(negedge clk);
        pop_check(busy);
        done_cnt = 0;
        wait_level(4'd15, 100, n);
        pop_check(n);
        pop_check(busy);
        pop_check(done);
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        pop_check(done_cnt);
        repeat (20) @(negedge clk);
        count_high(30, high);
        pop_check(high);

        // Fall from ON to OFF
        blink = 1'b0;
        push_exp("fall_cycles", 63);
        push_exp("fall_done_pulses", 1);
        push_exp("off_led_high", 0);
        done_cnt = 0;
        wait_level(4'd0, 200, n);
        pop_check(n);
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        pop_check(done_cnt);
        repeat (20) @(negedge clk);
        count_high(30, high);
        pop_check(high);

        // Reversal at level 7
        blink = 1'b1;
        push_exp("rev_reach7_cycles", 31);
        wait_level(4'd7, 200, n);
        pop_check(n);
        blink = 1'b0;
        push_exp("rev_max_level", 7);
        push_exp("rev_level_at6", 7);
        push_exp("rev_level_at7", 6);
        push_exp("rev_busy", 1);
        mx = 0;
        l6 = 0;
        l7 = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i <= 6 && int'(lvl) > mx) mx = int'(lvl);
            if (i == 6) l6 = int'(lvl);
            if (i == 7) l7 = int'(lvl);
        end
        pop_check(mx);
        pop_check(l6);
        pop_check(l7);
        pop_check(busy);

        // enable=0 at level 9
        blink = 1'b1;
        push_exp("en_reach9", 9);
        wait_level(4'd9, 200, n);
        pop_check(lvl);
        en = 1'b0;
        push_exp("en_off_level", 0);
        push_exp("en_off_busy", 0);
        push_exp("en_off_led", 0);
        push_exp("en_off_done", 0);
        push_exp("en_quiet_done", 0);
        push_exp("en_resume_busy", 1);
        push_exp("en_resume_level", 0);
        @(negedge clk);
        pop_check(lvl);
        pop_check(busy);
        pop_check(led);
        pop_check(done);
        dc = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dc++;
        end
        pop_check(dc);
        en = 1'b1;
        @(negedge clk);
        pop_check(busy);
        pop_check(lvl);

        // Asynchronous reset mid-ramp
        push_exp("mid_reach12", 12);
        wait_level(4'd12, 200, n);
        pop_check(lvl);
        repeat (16) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("mid_rst_led", 0);
        push_exp("mid_rst_level", 0);
        push_exp("mid_rst_busy", 0);
        push_exp("mid_rst_done", 0);
        pop_check(led);
        pop_check(lvl);
        pop_check(busy);
        pop_check(done);
        blink = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Hold level 8 by reversing direction every cycle
        blink = 1'b1;
        push_exp("steady_reach8", 8);
        wait_level(4'd8, 200, n);
        pop_check(lvl);
        repeat (20) begin
            blink = ~blink;
            @(negedge clk);
        end
        high = 0;
        repeat (60) begin
            blink = ~blink;
            @(negedge clk);
            if (led) high++;
        end
`ifdef LED_FADE_GAMMA_EN
        push_exp("steady_led_high", 16);
`else
        push_exp("steady_led_high", 32);
`endif
        push_exp("steady_level", 8);
        pop_check(high);
        pop_check(lvl);

        check_val("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
